addsub_iter: RTL



---
 rtl/addsub_iter_if.sv | 41 ++++
 rtl/addsub_iter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/addsub_iter_if.sv
// ---------------------------------------------------------------------------
// addsub_iter_if
// Bundles the request and response signals of the iterative add/subtract
// unit so they travel together as one port.
//   master : drives start/sub/a/b and observes busy/done/result/flags
//   slave  : the arithmetic unit itself
// Signals:
//   start    request a new operation (sampled only while idle)
//   sub      0 = a+b, 1 = a-b (sampled with start)
//   a, b     operands (sampled with start)
//   busy     high while slices are being processed
//   done     one-cycle pulse when result and flags update
//   result   last completed result, held between operations
//   carry    add: carry-out of MSB; sub: borrow
//   overflow signed two's-complement overflow of last result
//   zero     last result == 0
// ---------------------------------------------------------------------------
interface addsub_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry, overflow, zero
  );
endinterface

// File: rtl/addsub_iter.sv
// ---------------------------------------------------------------------------
// addsub_iter
// Multi-cycle add/subtract unit. Operands are processed CHUNK bits per clock,
// least-significant slice first, with the inter-slice carry held in a
// register so the combinational carry chain is only CHUNK bits long.
// Subtraction is a + ~b + 1, the +1 entering as the initial carry.
// Ports:
//   clock  system clock, rising-edge
//   reset  synchronous, active-high; aborts any operation without done
//   bus    addsub_iter_if.slave (start/sub/a/b in, busy/done/result/flags out)
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits per cycle; must divide WIDTH. CHUNK == WIDTH -> one slice.
// All outputs are driven straight from registers.
// ---------------------------------------------------------------------------
module addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clock,
  input  logic          reset,
  addsub_iter_if.slave  bus
);

  localparam int SLICES = WIDTH / CHUNK;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [WIDTH-1:0]        a_q, bx_q, acc_q, acc_d;
  logic                    sub_q, c_q;
  logic [CHUNK-1:0]        a_sl, b_sl;
  logic [CHUNK:0]          sum;
  logic                    accept, last;

  logic [WIDTH-1:0]        result_q;
  logic                    done_q, carry_q, ovf_q, zero_q;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_f(input logic a_msb, input logic bx_msb,
                                 input logic r_msb);
    return (a_msb == bx_msb) && (r_msb != a_msb);
  endfunction

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (idx_q == IDX_W'(SLICES - 1));

  // ---- slice adder: one CHUNK-wide slice per cycle --------------------------
  always_comb begin
    a_sl  = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_sl  = bx_q[int'(idx_q)*CHUNK +: CHUNK];
    sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_q};
    acc_d = acc_q;
    acc_d[int'(idx_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
  end

  // ---- FSM: state register -----------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state -----------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----------------------------------------------------------
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = done_q;
    bus.result   = result_q;
    bus.carry    = carry_q;
    bus.overflow = ovf_q;
    bus.zero     = zero_q;
  end

  // ---- control and visible results -----------------------------------------
  // Results move only on the final slice, so partial sums never appear.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        idx_q <= '0;
      end else if (state_q == RUN) begin
        idx_q <= idx_q + IDX_W'(1);
        if (last) begin
          result_q <= acc_d;
          carry_q  <= sum[CHUNK] ^ sub_q;
          ovf_q    <= ovf_f(a_q[WIDTH-1], bx_q[WIDTH-1], acc_d[WIDTH-1]);
          zero_q   <= (acc_d == '0);
          done_q   <= 1'b1;
        end
      end
    end
  end

  // ---- operand capture and accumulator (data, no reset) --------------------
  // b is inverted at capture for subtraction; the carry seed supplies the +1.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_q   <= bus.a;
      bx_q  <= bus.sub ? ~bus.b : bus.b;
      sub_q <= bus.sub;
      c_q   <= bus.sub;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      c_q   <= sum[CHUNK];
    end
  end

endmodule
